ram2_word_ctrl: RTL and testbench
=================================

Name: ram2_word_ctrl

Overview:
- Initiator for the 2-bit-wide, 576-deep, single-port fakeram macro used by the serv_fr register file.
- Accepts 32-bit word read/write requests on a valid/ready interface.
- Serializes each request into 16 sequential 2-bit RAM beats and returns read data on a response handshake.
- Sits between the register-file front end and the RAM's rd_out/addr_in/we_in/wd_in/w_mask_in/ce_in port.

Parameters:
- WORD_WIDTH, 32: request word width; must be a multiple of RAM_BITS.
- RAM_BITS, 2: RAM data width.
- RAM_ADDR_WIDTH, 10: RAM address width.
- NUM_WORDS, 36: legal word count (576/16).
- WORD_ADDR_WIDTH, 6: request address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  WORD_ADDR_WIDTH  word address.
- req_wdata  in  WORD_WIDTH  write data.
- req_wmask  in  WORD_WIDTH/8  per-byte write enable.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_rdata  out  WORD_WIDTH  read data.
- rsp_err  out  1  out-of-range address.
- ram_addr_out  out  RAM_ADDR_WIDTH  to RAM addr_in.
- ram_we_out  out  1  to RAM we_in.
- ram_wd_out  out  RAM_BITS  to RAM wd_in.
- ram_w_mask_out  out  RAM_BITS  to RAM w_mask_in.
- ram_ce_out  out  1  to RAM ce_in.
- ram_rd_in  in  RAM_BITS  from RAM rd_out.

Behaviour:
- One clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All ram_* outputs 0.
  - Beat counter 0.
- All outputs are registered.
- Beat mapping (BEATS = WORD_WIDTH/RAM_BITS = 16):
  - Beat k carries word bits [2k+1:2k], issued LSB first.
  - ram_addr_out = req_addr*16 + k, computed at RAM_ADDR_WIDTH with no wrap.
- RAM timing is a synchronous read: rd_out for a beat sampled at edge E is valid after E and is captured at the next edge.
- States: IDLE, WR, RD, RD_TAIL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at edge E0, latch the request and drop req_ready.
  - req_addr >= NUM_WORDS: go to RESP with rsp_err=1 and rsp_rdata=0; no RAM access. rsp_valid is high in the cycle after E0.
  - Otherwise go to WR or RD with beat=0.
- WR:
  - Each cycle drive we=1 and wd = the beat's bits.
  - w_mask = {2{req_wmask[k/4]}}.
  - ce = req_wmask[k/4]. Masked-off beats deassert ce, with no change in timing.
  - After the edge sampling beat 15 (E16), go to RESP with rsp_rdata=0.
  - Write latency: rsp_valid in the cycle after E16.
- RD:
  - Each cycle drive ce=1, we=0, w_mask=0, wd=0.
  - At each edge after the first, shift ram_rd_in into the data register at beat position k-1.
  - After E16, go to RD_TAIL with ce=0.
- RD_TAIL: capture beat 15 at E17, then go to RESP. Read latency: rsp_valid in the cycle after E17.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On handshake, go to IDLE with rsp_valid=0 and req_ready=1.
  - The next request is accepted no earlier than the cycle after the response handshake. There is no overlap, so a simultaneous req/rsp is impossible.
- In any non-beat cycle (IDLE, RD_TAIL, RESP), all ram_* outputs are 0.
- Reset mid-operation:
  - All outputs return to reset values immediately (ce drops asynchronously).
  - A partial write stays partially committed; no response is generated.
- req_wmask is ignored for reads. A write with all-zero mask still takes 16 cycles with ce never asserted.

Test Plan:
- Write 0xA5A51234 to word 3, mask 0xF, then read word 3 -> writes hit ram_addr 48..63 LSB-first; write rsp_valid 16 cycles after handshake; read rsp_valid 17 cycles after handshake with rsp_rdata=0xA5A51234, rsp_err=0.
- After the above, write 0xFFFFFFFF to word 3 with mask 0x2 -> ram_ce_out high only for beats 4..7 (addr 52..55); reread returns 0xA5A5FF34.
- Read word 36 -> rsp_err=1, rsp_rdata=0, rsp_valid the cycle after handshake, ram_ce_out never asserted.
- Read word 35 -> ram_addr_out sweeps 560..575, with no wrap and no error.
- Hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata/rsp_err stable, req_ready=0 and a new req_valid ignored; accepted one cycle after the rsp handshake.
- Assert rst_n=0 during read beat 7 -> ram_ce_out and rsp_valid low immediately; after release, req_ready=1 and a fresh read of word 3 returns correct data.

Source files
------------

// File: rtl/ram2_word_ctrl.sv
// Word-level initiator for the 2-bit fakeram used by the serv_fr register file.
// Each 32-bit request becomes 16 LSB-first RAM beats; reads add one tail cycle for the synchronous read.
module ram2_word_ctrl #(
    parameter int WORD_WIDTH      = 32,
    parameter int RAM_BITS        = 2,
    parameter int RAM_ADDR_WIDTH  = 10,
    parameter int NUM_WORDS       = 36,
    parameter int WORD_ADDR_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [WORD_ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0]      req_wdata,
    input  logic [WORD_WIDTH/8-1:0]    req_wmask,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WORD_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic [RAM_ADDR_WIDTH-1:0]  ram_addr_out,
    output logic                       ram_we_out,
    output logic [RAM_BITS-1:0]        ram_wd_out,
    output logic [RAM_BITS-1:0]        ram_w_mask_out,
    output logic                       ram_ce_out,
    input  logic [RAM_BITS-1:0]        ram_rd_in
);
    localparam int BEATS  = WORD_WIDTH / RAM_BITS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int MASK_W = WORD_WIDTH / 8;
    localparam logic [BEAT_W-1:0]        LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [WORD_ADDR_WIDTH:0] ADDR_LIMIT = NUM_WORDS[WORD_ADDR_WIDTH:0];

    typedef enum logic [2:0] {IDLE, WR, RD, RD_TAIL, RESP} state_t;

    state_t                      state_q, state_d;
    logic [BEAT_W-1:0]           beat_q, beat_d, next_beat;
    logic [WORD_WIDTH-1:0]       wdata_q, shift_q;
    logic [MASK_W-1:0]           wmask_q;
    logic [RAM_ADDR_WIDTH-1:0]   base_q, base_new;
    logic                        load_req, shift_en, wr_en;
    logic                        req_ready_d, rsp_valid_d, rsp_err_d;
    logic [WORD_WIDTH-1:0]       rsp_rdata_d;
    logic [RAM_ADDR_WIDTH-1:0]   ram_addr_d;
    logic                        ram_we_d, ram_ce_d;
    logic [RAM_BITS-1:0]         ram_wd_d, ram_mask_d;

    function automatic logic [RAM_BITS-1:0] beat_data(input logic [WORD_WIDTH-1:0] word,
                                                      input logic [BEAT_W-1:0] k);
        logic [WORD_WIDTH-1:0] sh;
        sh = word >> (int'(k) * RAM_BITS);
        return sh[RAM_BITS-1:0];
    endfunction

    // Byte enable that covers beat k.
    function automatic logic beat_en(input logic [MASK_W-1:0] mask, input logic [BEAT_W-1:0] k);
        logic [MASK_W-1:0] sh;
        sh = mask >> ((int'(k) * RAM_BITS) / 8);
        return sh[0];
    endfunction

    function automatic logic [RAM_ADDR_WIDTH-1:0] beat_addr(input logic [RAM_ADDR_WIDTH-1:0] base,
                                                            input logic [BEAT_W-1:0] k);
        return base + RAM_ADDR_WIDTH'(k);
    endfunction

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        next_beat   = beat_q + BEAT_W'(1);
        base_new    = RAM_ADDR_WIDTH'(req_addr) << BEAT_W;
        load_req    = 1'b0;
        shift_en    = 1'b0;
        wr_en       = 1'b0;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        ram_addr_d  = '0;
        ram_we_d    = 1'b0;
        ram_wd_d    = '0;
        ram_mask_d  = '0;
        ram_ce_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_req    = 1'b1;
                    req_ready_d = 1'b0;
                    beat_d      = '0;
                    if ({1'b0, req_addr} >= ADDR_LIMIT) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (req_we) begin
                        state_d    = WR;
                        wr_en      = beat_en(req_wmask, '0);
                        ram_we_d   = 1'b1;
                        ram_ce_d   = wr_en;
                        ram_mask_d = {RAM_BITS{wr_en}};
                        ram_wd_d   = beat_data(req_wdata, '0);
                        ram_addr_d = base_new;
                    end else begin
                        state_d    = RD;
                        ram_ce_d   = 1'b1;
                        ram_addr_d = base_new;
                    end
                end
            end
            WR: begin
                if (beat_q == LAST_BEAT) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end else begin
                    beat_d     = next_beat;
                    wr_en      = beat_en(wmask_q, next_beat);
                    ram_we_d   = 1'b1;
                    ram_ce_d   = wr_en;
                    ram_mask_d = {RAM_BITS{wr_en}};
                    ram_wd_d   = beat_data(wdata_q, next_beat);
                    ram_addr_d = beat_addr(base_q, next_beat);
                end
            end
            RD: begin
                // Read data lags the issued beat by one cycle.
                shift_en = (beat_q != '0);
                if (beat_q == LAST_BEAT) begin
                    state_d = RD_TAIL;
                end else begin
                    beat_d     = next_beat;
                    ram_ce_d   = 1'b1;
                    ram_addr_d = beat_addr(base_q, next_beat);
                end
            end
            RD_TAIL: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = {ram_rd_in, shift_q[WORD_WIDTH-1:RAM_BITS]};
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            ram_addr_out   <= '0;
            ram_we_out     <= 1'b0;
            ram_wd_out     <= '0;
            ram_w_mask_out <= '0;
            ram_ce_out     <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            req_ready      <= req_ready_d;
            rsp_valid      <= rsp_valid_d;
            rsp_rdata      <= rsp_rdata_d;
            rsp_err        <= rsp_err_d;
            ram_addr_out   <= ram_addr_d;
            ram_we_out     <= ram_we_d;
            ram_wd_out     <= ram_wd_d;
            ram_w_mask_out <= ram_mask_d;
            ram_ce_out     <= ram_ce_d;
        end
    end

    // Request payload and read assembly carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (load_req) begin
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            base_q  <= base_new;
        end
        if (shift_en) begin
            shift_q <= {ram_rd_in, shift_q[WORD_WIDTH-1:RAM_BITS]};
        end
    end
endmodule

// File: tb/tb_ram2_word_ctrl.sv
// Self-checking bench for ram2_word_ctrl with a behavioural 2x576 fakeram and a word-level scoreboard.
module tb_ram2_word_ctrl;
    localparam int NW = 36;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [9:0]  ram_addr_out;
    logic        ram_we_out, ram_ce_out;
    logic [1:0]  ram_wd_out, ram_w_mask_out, ram_rd_in;

    always #5 clk = ~clk;

    ram2_word_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_addr_out(ram_addr_out), .ram_we_out(ram_we_out), .ram_wd_out(ram_wd_out),
        .ram_w_mask_out(ram_w_mask_out), .ram_ce_out(ram_ce_out), .ram_rd_in(ram_rd_in)
    );

    // Behavioural fakeram: synchronous read, bit-masked write.
    logic [1:0] ram [576];
    initial begin
        for (int i = 0; i < 576; i++) ram[i] = 2'b00;
        ram_rd_in = 2'b00;
    end
    always @(posedge clk) begin
        if (ram_ce_out && int'(ram_addr_out) < 576) begin
            if (ram_we_out)
                ram[ram_addr_out] <= (ram[ram_addr_out] & ~ram_w_mask_out) | (ram_wd_out & ram_w_mask_out);
            else
                ram_rd_in <= ram[ram_addr_out];
        end
    end

    typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [NW];
    logic [15:0] tr [64];
    int total = 0;
    int bad   = 0;

    function automatic logic [15:0] wr_beat(input logic [31:0] d, input logic [3:0] m,
                                            input int waddr, input int k);
        logic [1:0] bits;
        logic       en;
        bits = d[2*k +: 2];
        en   = m[k/4];
        return {en, 1'b1, {2{en}}, bits, 10'(waddr*16 + k)};
    endfunction

    function automatic logic [15:0] rd_beat(input int waddr, input int k);
        return {1'b1, 1'b0, 2'b00, 2'b00, 10'(waddr*16 + k)};
    endfunction

    task automatic predict(input logic we, input logic [5:0] addr, input logic [31:0] d, input logic [3:0] m);
        exp_t e;
        if (int'(addr) >= NW) e = '{rdata: 32'h0, err: 1'b1};
        else if (we) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[addr][8*b +: 8] = d[8*b +: 8];
            e = '{rdata: 32'h0, err: 1'b0};
        end else e = '{rdata: ref_mem[addr], err: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() == 0) e = '{rdata: 32'hxxxxxxxx, err: 1'bx};
        else e = exp_q.pop_front();
    endtask

    // Present a request for one edge; returns one negedge after acceptance.
    task automatic start_req(input logic we, input logic [5:0] addr, input logic [31:0] d, input logic [3:0] m);
        req_we = we; req_addr = addr; req_wdata = d; req_wmask = m;
        req_valid = 1'b1;
        predict(we, addr, d, m);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic record(input int n);
        tr[n] = {ram_ce_out, ram_we_out, ram_w_mask_out, ram_wd_out, ram_addr_out};
    endtask

    // Latency counts edges from acceptance; -1 means the response never came.
    task automatic wait_rsp(output int lat);
        int n;
        n = 1;
        record(n);
        while (rsp_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            record(n);
        end
        lat = (rsp_valid === 1'b1) ? n : -1;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NW; i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            total++;
            if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
                bad++;
                $display("FAIL reset_rsp pass=%0d got rdy=%b vld=%b err=%b rdata=%h want 1 0 0 0",
                         pass, req_ready, rsp_valid, rsp_err, rsp_rdata);
            end
            total++;
            if ({ram_ce_out, ram_we_out, ram_w_mask_out, ram_wd_out, ram_addr_out} !== 16'h0) begin
                bad++;
                $display("FAIL reset_ram pass=%0d got %h want 0000", pass,
                         {ram_ce_out, ram_we_out, ram_w_mask_out, ram_wd_out, ram_addr_out});
            end
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    // Write (or read back) one word and check latency, every beat, the idle cycle and the response.
    task automatic test_word(input string tag, input logic we, input int waddr,
                             input logic [31:0] d, input logic [3:0] m);
        int   lat;
        exp_t e;
        start_req(we, 6'(waddr), d, m);
        wait_rsp(lat);
        total++;
        if (lat !== (we ? 17 : 18)) begin
            bad++;
            $display("FAIL %s_latency got %0d want %0d", tag, lat, we ? 17 : 18);
        end
        for (int k = 0; k < 16; k++) begin
            logic [15:0] want;
            want = we ? wr_beat(d, m, waddr, k) : rd_beat(waddr, k);
            total++;
            if (tr[k+1] !== want) begin
                bad++;
                $display("FAIL %s_beat%0d got %h want %h", tag, k, tr[k+1], want);
            end
        end
        total++;
        if (tr[17] !== 16'h0) begin
            bad++;
            $display("FAIL %s_ram_idle got %h want 0000", tag, tr[17]);
        end
        pop_exp(e);
        total++;
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            bad++;
            $display("FAIL %s_rsp got %h/%b want %h/%b", tag, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        ack_rsp();
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL %s_after_ack got vld=%b rdy=%b want 0 1", tag, rsp_valid, req_ready);
        end
    endtask

    task automatic test_write_read();
        test_word("wr3", 1'b1, 3, 32'hA5A51234, 4'hF);
        test_word("rd3", 1'b0, 3, 32'h0, 4'h0);
    endtask

    task automatic test_partial_mask();
        test_word("wr3m", 1'b1, 3, 32'hFFFFFFFF, 4'h2);
        test_word("rd3m", 1'b0, 3, 32'h0, 4'h0);
        test_word("wr5z", 1'b1, 5, 32'hFFFFFFFF, 4'h0);
        test_word("rd5z", 1'b0, 5, 32'h0, 4'h0);
    endtask

    task automatic test_range();
        int   lat;
        exp_t e;
        start_req(1'b0, 6'd36, 32'h0, 4'h0);
        wait_rsp(lat);
        total++;
        if (lat !== 1 || tr[1] !== 16'h0) begin
            bad++;
            $display("FAIL err_latency got lat=%0d ram=%h want lat=1 ram=0000", lat, tr[1]);
        end
        pop_exp(e);
        total++;
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            bad++;
            $display("FAIL err_rsp got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
        end
        ack_rsp();
        test_word("rd35", 1'b0, 35, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        int          lat;
        exp_t        e;
        logic [32:0] held;
        test_word("wr10", 1'b1, 10, 32'h0BADF00D, 4'hF);
        start_req(1'b0, 6'd10, 32'h0, 4'h0);
        wait_rsp(lat);
        held = {rsp_rdata, rsp_err};
        req_we = 1'b0; req_addr = 6'd3; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, req_ready, rsp_rdata, rsp_err} !== {1'b1, 1'b0, held}) begin
                bad++;
                $display("FAIL hold_c%0d got vld=%b rdy=%b %h want 1 0 %h", c, rsp_valid, req_ready,
                         {rsp_rdata, rsp_err}, held);
            end
        end
        pop_exp(e);
        total++;
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            bad++;
            $display("FAIL rd10_rsp got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
        end
        ack_rsp();
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_ready got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
        predict(1'b0, 6'd3, 32'h0, 4'h0);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept got rdy=%b want 0", req_ready);
        end
        wait_rsp(lat);
        pop_exp(e);
        total++;
        if (lat !== 18 || {rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
            bad++;
            $display("FAIL b2b_rsp got lat=%0d %h/%b want lat=18 %h/%b", lat, rsp_rdata, rsp_err, e.rdata, e.err);
        end
        ack_rsp();
    endtask

    task automatic test_reset_mid();
        start_req(1'b0, 6'd3, 32'h0, 4'h0);
        repeat (7) @(negedge clk);
        total++;
        if ({ram_ce_out, ram_addr_out} !== {1'b1, 10'd55}) begin
            bad++;
            $display("FAIL mid_beat7 got ce=%b addr=%0d want 1 55", ram_ce_out, ram_addr_out);
        end
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        total++;
        if ({ram_ce_out, rsp_valid, req_ready, ram_addr_out} !== {1'b0, 1'b0, 1'b1, 10'd0}) begin
            bad++;
            $display("FAIL mid_reset got ce=%b vld=%b rdy=%b addr=%0d want 0 0 1 0",
                     ram_ce_out, rsp_valid, req_ready, ram_addr_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_word("rd3r", 1'b0, 3, 32'h0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_mask();
        test_range();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish before timeout");
        $fatal(1, "timeout");
    end
endmodule
